// File: rtl/int_arbiter.sv
// int_arbiter: edge-latched interrupt arbiter between the IRQ lines and CP0.
// Latency: IRQ edge at cycle N -> pend at N+1 -> WAIT_WB at N+2; a retirement at
//          cycle M >= N+2 produces the ENTER strobes during M+1.
// Backpressure: entry waits in WAIT_WB for a retiring instruction (in_WB_VALID)
//               with no bound, and abandons the entry if the source stops
//               being eligible.
// Build option: define INT_NEST_EN to allow nested handlers. Only higher
//               priority sources may preempt, and `eret` retires only the
//               innermost handler. With it undefined, one handler is in service
//               at a time and `eret` clears every in-service bit.
// Ports:
//   in_CLK, in_RST            clock, asynchronous active-high reset
//   in_IRQ[3:0]               raw request lines, rising-edge sensitive, bit 3 highest
//   in_IE, in_INM[3:0]        CP0 global enable and per-source mask (1 = blocked)
//   in_WB_VALID, in_WB_PC     retiring instruction and its PC
//   in_ERET                   retiring instruction is `eret`
//   out_BK, out_NIE           one-cycle IE load pulse to CP0 and the IE value
//   out_EPC_WE, out_EPC       EPC write strobe and value (retiring PC + 4)
//   out_FLUSH, out_VEC_PC     flush/redirect strobe and handler vector
//   out_CODE                  accepted source index
//   out_ISR[3:0]              in-service bits
module int_arbiter #(
  parameter logic [31:0] VEC_BASE  = 32'h0000_0800,
  parameter int          VEC_SHIFT = 4
) (
  input  logic        in_CLK,
  input  logic        in_RST,
  input  logic [3:0]  in_IRQ,
  input  logic        in_IE,
  input  logic [3:0]  in_INM,
  input  logic        in_WB_VALID,
  input  logic [31:0] in_WB_PC,
  input  logic        in_ERET,
  output logic        out_BK,
  output logic        out_NIE,
  output logic        out_EPC_WE,
  output logic [31:0] out_EPC,
  output logic        out_FLUSH,
  output logic [31:0] out_VEC_PC,
  output logic [1:0]  out_CODE,
  output logic [3:0]  out_ISR
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_WB = 2'd1,
    ST_ENTER   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  irq_q;
  logic [3:0]  pend, pend_nxt;
  logic [3:0]  isr, isr_nxt;
  logic [3:0]  rise;
  logic [3:0]  prio_ok;
  logic [3:0]  elig;
  logic [1:0]  sel;
  logic [1:0]  sel_q, sel_nxt;
  logic        enter_go;
  logic        eret_fire;

  assign rise = in_IRQ & ~irq_q;

  // The pipeline cannot retire during ENTER (it is being flushed), so any
  // `eret` seen there is ignored; this also keeps the two out_BK sources apart.
  assign eret_fire = in_WB_VALID & in_ERET & (state != ST_ENTER);

`ifdef INT_NEST_EN
  logic [1:0] isr_top;

  always_comb begin
    isr_top = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (isr[i]) isr_top = 2'(i);
    end
  end

  // Only sources strictly above the innermost active handler may preempt.
  always_comb begin
    prio_ok = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      prio_ok[i] = (isr == 4'b0000) || (i > int'(isr_top));
    end
  end
`else
  assign prio_ok = {4{isr == 4'b0000}};
`endif

  assign elig = pend & ~in_INM & {4{in_IE}} & prio_ok;

  always_comb begin
    sel = 2'd0;
    if      (elig[3]) sel = 2'd3;
    else if (elig[2]) sel = 2'd2;
    else if (elig[1]) sel = 2'd1;
    else              sel = 2'd0;
  end

  // Next state and the single-cycle "take the interrupt" decision.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    enter_go  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (elig != 4'b0000) begin
          sel_nxt   = sel;
          state_nxt = ST_WAIT_WB;
        end
      end
      ST_WAIT_WB: begin
        if (!elig[sel_q]) begin
          state_nxt = ST_IDLE;
        end else if (in_WB_VALID && in_ERET) begin
          state_nxt = ST_IDLE;
        end else if (in_WB_VALID) begin
          enter_go  = 1'b1;
          state_nxt = ST_ENTER;
        end
      end
      ST_ENTER: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Pending bits: a fresh edge in the same cycle as the clear wins.
  always_comb begin
    pend_nxt = pend;
    if (state == ST_ENTER) pend_nxt[sel_q] = 1'b0;
    pend_nxt = pend_nxt | rise;
  end

  // In-service bits: set on ENTER, retired by `eret` (never in the same cycle).
  always_comb begin
    isr_nxt = isr;
    if (state == ST_ENTER) isr_nxt[sel_q] = 1'b1;
    if (eret_fire) begin
`ifdef INT_NEST_EN
      if (isr != 4'b0000) isr_nxt[isr_top] = 1'b0;
`else
      isr_nxt = 4'b0000;
`endif
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state <= ST_IDLE;
      sel_q <= 2'd0;
      irq_q <= 4'b0000;
      pend  <= 4'b0000;
      isr   <= 4'b0000;
    end else begin
      state <= state_nxt;
      sel_q <= sel_nxt;
      irq_q <= in_IRQ;
      pend  <= pend_nxt;
      isr   <= isr_nxt;
    end
  end

  // Outputs are registered so the strobes line up with the ENTER state.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      out_BK     <= 1'b0;
      out_NIE    <= 1'b0;
      out_EPC_WE <= 1'b0;
      out_FLUSH  <= 1'b0;
      out_EPC    <= 32'd0;
      out_VEC_PC <= 32'd0;
      out_CODE   <= 2'd0;
    end else begin
      out_BK     <= enter_go | eret_fire;
      out_NIE    <= eret_fire;
      out_EPC_WE <= enter_go;
      out_FLUSH  <= enter_go;
      if (enter_go) begin
        out_EPC    <= in_WB_PC + 32'd4;
        out_VEC_PC <= VEC_BASE + ({30'd0, sel_q} << VEC_SHIFT);
        out_CODE   <= sel_q;
      end
    end
  end

  assign out_ISR = isr;

endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: directed checks of the interrupt arbiter.
// A vector table covers entry, priority, eret and masking; hand-written
// sequences cover the wait/IE-drop, nesting and reset-abort corner cases.
module tb_int_arbiter;

  logic        in_CLK = 1'b0;
  logic        in_RST;
  logic [3:0]  in_IRQ;
  logic        in_IE;
  logic [3:0]  in_INM;
  logic        in_WB_VALID;
  logic [31:0] in_WB_PC;
  logic        in_ERET;
  logic        out_BK;
  logic        out_NIE;
  logic        out_EPC_WE;
  logic [31:0] out_EPC;
  logic        out_FLUSH;
  logic [31:0] out_VEC_PC;
  logic [1:0]  out_CODE;
  logic [3:0]  out_ISR;

  int total  = 0;
  int passed = 0;

  int_arbiter dut (
    .in_CLK      (in_CLK),
    .in_RST      (in_RST),
    .in_IRQ      (in_IRQ),
    .in_IE       (in_IE),
    .in_INM      (in_INM),
    .in_WB_VALID (in_WB_VALID),
    .in_WB_PC    (in_WB_PC),
    .in_ERET     (in_ERET),
    .out_BK      (out_BK),
    .out_NIE     (out_NIE),
    .out_EPC_WE  (out_EPC_WE),
    .out_EPC     (out_EPC),
    .out_FLUSH   (out_FLUSH),
    .out_VEC_PC  (out_VEC_PC),
    .out_CODE    (out_CODE),
    .out_ISR     (out_ISR)
  );

  always #5 in_CLK = ~in_CLK;

  typedef struct {
    logic [3:0]  irq;
    logic        ie;
    logic [3:0]  inm;
    logic        wb;
    logic [31:0] pc;
    logic        eret;
    logic        bk;
    logic        nie;
    logic        we;
    logic        fl;
    logic [31:0] epc;
    logic [31:0] vec;
    logic [1:0]  code;
    logic [3:0]  isr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] irq, input logic ie, input logic [3:0] inm,
                     input logic wb, input logic [31:0] pc, input logic eret,
                     input logic bk, input logic nie, input logic we, input logic fl,
                     input logic [31:0] epc, input logic [31:0] vec,
                     input logic [1:0] code, input logic [3:0] isr);
    vec_t v;
    v.irq = irq; v.ie = ie; v.inm = inm; v.wb = wb; v.pc = pc; v.eret = eret;
    v.bk = bk; v.nie = nie; v.we = we; v.fl = fl;
    v.epc = epc; v.vec = vec; v.code = code; v.isr = isr;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else
      passed++;
  endtask

  task automatic step();
    @(posedge in_CLK);
    #1;
  endtask

  task automatic drive(input logic [3:0] irq, input logic ie, input logic [3:0] inm,
                       input logic wb, input logic [31:0] pc, input logic eret);
    in_IRQ = irq; in_IE = ie; in_INM = inm;
    in_WB_VALID = wb; in_WB_PC = pc; in_ERET = eret;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".bk"},   32'(out_BK),     32'd0);
    chk({tag, ".nie"},  32'(out_NIE),    32'd0);
    chk({tag, ".we"},   32'(out_EPC_WE), 32'd0);
    chk({tag, ".fl"},   32'(out_FLUSH),  32'd0);
    chk({tag, ".epc"},  out_EPC,         32'd0);
    chk({tag, ".vec"},  out_VEC_PC,      32'd0);
    chk({tag, ".code"}, 32'(out_CODE),   32'd0);
    chk({tag, ".isr"},  32'(out_ISR),    32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // irq ie inm wb pc eret | bk nie we fl epc vec code isr
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h0,  32'h0,  2'd0,4'b0000);
    add(4'b0010,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h0,  32'h0,  2'd0,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h0,  32'h0,  2'd0,4'b0000);
    add(4'b0000,1,4'b0000,1,32'h100,0, 1,0,1,1, 32'h104,32'h810,2'd1,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h104,32'h810,2'd1,4'b0010);
    add(4'b0000,1,4'b0000,1,32'h900,1, 1,1,0,0, 32'h104,32'h810,2'd1,4'b0000);
    add(4'b0101,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h104,32'h810,2'd1,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h104,32'h810,2'd1,4'b0000);
    add(4'b0000,1,4'b0000,1,32'h200,0, 1,0,1,1, 32'h204,32'h820,2'd2,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h204,32'h820,2'd2,4'b0100);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h204,32'h820,2'd2,4'b0100);
    add(4'b0000,1,4'b0000,1,32'h904,1, 1,1,0,0, 32'h204,32'h820,2'd2,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h204,32'h820,2'd2,4'b0000);
    add(4'b0000,1,4'b0000,1,32'h300,0, 1,0,1,1, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h304,32'h800,2'd0,4'b0001);
    add(4'b0000,1,4'b0000,1,32'h908,1, 1,1,0,0, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0100,1,4'b0100,0,32'h0,  0, 0,0,0,0, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0000,1,4'b0100,0,32'h0,  0, 0,0,0,0, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0000,1,4'b0100,1,32'h400,0, 0,0,0,0, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h304,32'h800,2'd0,4'b0000);
    add(4'b0000,1,4'b0000,1,32'h500,0, 1,0,1,1, 32'h504,32'h820,2'd2,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h504,32'h820,2'd2,4'b0100);
    add(4'b0000,1,4'b0000,1,32'h90c,1, 1,1,0,0, 32'h504,32'h820,2'd2,4'b0000);
    add(4'b0000,1,4'b0000,0,32'h0,  0, 0,0,0,0, 32'h504,32'h820,2'd2,4'b0000);

    // Reset state.
    in_RST = 1'b1;
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    step();
    chk_all_zero("reset");
    in_RST = 1'b0;

    // Table-driven vectors: inputs for one cycle, outputs after its edge.
    for (int i = 0; i < tbl.size(); i++) begin
      string t;
      t = $sformatf("v%0d", i);
      drive(tbl[i].irq, tbl[i].ie, tbl[i].inm, tbl[i].wb, tbl[i].pc, tbl[i].eret);
      step();
      chk({t, ".bk"},   32'(out_BK),     32'(tbl[i].bk));
      chk({t, ".nie"},  32'(out_NIE),    32'(tbl[i].nie));
      chk({t, ".we"},   32'(out_EPC_WE), 32'(tbl[i].we));
      chk({t, ".fl"},   32'(out_FLUSH),  32'(tbl[i].fl));
      chk({t, ".epc"},  out_EPC,         tbl[i].epc);
      chk({t, ".vec"},  out_VEC_PC,      tbl[i].vec);
      chk({t, ".code"}, 32'(out_CODE),   32'(tbl[i].code));
      chk({t, ".isr"},  32'(out_ISR),    32'(tbl[i].isr));
    end

    // Waiting without a retirement, then IE drops: no entry may happen.
    for (int c = 0; c < 5; c++) begin
      drive((c == 0) ? 4'b1000 : 4'b0000, (c >= 2) ? 1'b0 : 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
      step();
      chk($sformatf("wait%0d.we", c), 32'(out_EPC_WE), 32'd0);
      chk($sformatf("wait%0d.fl", c), 32'(out_FLUSH),  32'd0);
    end
    drive(4'b0000, 1'b0, 4'b0000, 1'b1, 32'h40, 1'b0);
    step();
    chk("ie_off.we",  32'(out_EPC_WE), 32'd0);
    chk("ie_off.epc", out_EPC,         32'h504);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'hA00, 1'b0);
    step();
    chk("ie_on.we",   32'(out_EPC_WE), 32'd1);
    chk("ie_on.code", 32'(out_CODE),   32'd3);
    chk("ie_on.vec",  out_VEC_PC,      32'h830);
    chk("ie_on.epc",  out_EPC,         32'hA04);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("ie_on.isr", 32'(out_ISR), 32'b1000);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h910, 1'b1);
    step();
    chk("ie_on.eret_bk", 32'(out_BK),  32'd1);
    chk("ie_on.eret_isr", 32'(out_ISR), 32'd0);

    // Nesting: source 0 in service, then source 3 requests.
    drive(4'b0001, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h600, 1'b0);
    step();
    chk("nest.s0_we",   32'(out_EPC_WE), 32'd1);
    chk("nest.s0_code", 32'(out_CODE),   32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("nest.s0_isr", 32'(out_ISR), 32'b0001);
    drive(4'b1000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h700, 1'b0);
    step();
`ifdef INT_NEST_EN
    chk("nest.s3_we",   32'(out_EPC_WE), 32'd1);
    chk("nest.s3_code", 32'(out_CODE),   32'd3);
    chk("nest.s3_epc",  out_EPC,         32'h704);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("nest.isr2", 32'(out_ISR), 32'b1001);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h920, 1'b1);
    step();
    chk("nest.eret1_bk",  32'(out_BK),  32'd1);
    chk("nest.eret1_nie", 32'(out_NIE), 32'd1);
    chk("nest.eret1_isr", 32'(out_ISR), 32'b0001);
    step();
    chk("nest.eret2_isr", 32'(out_ISR), 32'b0000);
`else
    chk("nest.blocked_we",  32'(out_EPC_WE), 32'd0);
    chk("nest.blocked_epc", out_EPC,         32'h604);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("nest.isr_hold", 32'(out_ISR), 32'b0001);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h920, 1'b1);
    step();
    chk("nest.eret_bk",  32'(out_BK),  32'd1);
    chk("nest.eret_nie", 32'(out_NIE), 32'd1);
    chk("nest.eret_isr", 32'(out_ISR), 32'b0000);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("nest.after_bk", 32'(out_BK), 32'd0);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h710, 1'b0);
    step();
    chk("nest.late_we",   32'(out_EPC_WE), 32'd1);
    chk("nest.late_code", 32'(out_CODE),   32'd3);
    chk("nest.late_epc",  out_EPC,         32'h714);
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    chk("nest.late_isr", 32'(out_ISR), 32'b1000);
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'h924, 1'b1);
    step();
    chk("nest.late_eret_isr", 32'(out_ISR), 32'b0000);
`endif

    // Reset while waiting for a retirement aborts the entry.
    drive(4'b0010, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0);
    step();
    drive(4'b0000, 1'b1, 4'b0000, 1'b1, 32'hB00, 1'b0);
    in_RST = 1'b1;
    step();
    chk_all_zero("rst_wait");
    in_RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("post_rst%0d.we", c), 32'(out_EPC_WE), 32'd0);
      chk($sformatf("post_rst%0d.bk", c), 32'(out_BK),     32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/int_arbiter.md
# int_arbiter

Interrupt controller that sits between the four external interrupt lines and the CP0 register block of the pipelined CPU. It edge-latches requests, filters them through the CP0 enable/mask state, and selects the highest-priority eligible source. It waits for a retiring instruction, then in one cycle writes EPC, clears IE, flushes the pipeline and redirects fetch to the source's vector. It tracks in-service sources so that `eret` re-enables IE and retires the active handler.

## Interface
Parameters:
- VEC_BASE, 32'h0000_0800, handler address of source 0.
- VEC_SHIFT, 4, log2 of the byte stride between vectors.

Ports (reset in_RST, asynchronous, active-high; clock in_CLK):
- in_CLK  input  1  clock; all state updates on rising edge.
- in_RST  input  1  asynchronous active-high reset.
- in_IRQ  input  4  raw request lines, rising-edge sensitive; bit 3 highest priority.
- in_IE  input  1  global interrupt enable from CP0.
- in_INM  input  4  mask from CP0; bit i = 1 blocks source i.
- in_WB_VALID  input  1  a valid instruction retires this cycle.
- in_WB_PC  input  32  PC of the retiring instruction.
- in_ERET  input  1  retiring instruction is `eret`; qualified by in_WB_VALID.
- out_BK  output  1  one-cycle pulse to CP0: load IE from out_NIE.
- out_NIE  output  1  IE value for CP0: 0 on entry, 1 on `eret`.
- out_EPC_WE  output  1  EPC write strobe.
- out_EPC  output  32  value for EPC.
- out_FLUSH  output  1  pipeline flush / fetch redirect strobe.
- out_VEC_PC  output  32  redirect target, valid while out_FLUSH = 1.
- out_CODE  output  2  index of the accepted source, valid with out_EPC_WE.
- out_ISR  output  4  in-service bits.

## Operation
- Edge detect: a registered copy of in_IRQ. A rising edge on bit i sets pend[i].
- pend[i] clears on ENTER for source i. If a new edge arrives in the same cycle, the set wins.
- Eligibility: elig = pend & ~in_INM & {4{in_IE}} & prio_ok. sel is the highest set bit of elig.
- States:
  - IDLE: if elig != 0, latch sel and go to WAIT_WB.
  - WAIT_WB:
    - If the latched source is no longer eligible (IE dropped, masked, or pend cleared), go to IDLE.
    - Else, if in_WB_VALID & in_ERET, perform the `eret` actions and go to IDLE; there is no entry this time.
    - Else, if in_WB_VALID, register EPC = in_WB_PC + 4 and go to ENTER.
  - ENTER (exactly 1 cycle):
    - Assert out_EPC_WE, out_FLUSH and out_BK with out_NIE = 0.
    - out_CODE = sel; out_VEC_PC = VEC_BASE + (sel << VEC_SHIFT).
    - Set ISR[sel], clear pend[sel], go to IDLE.
- `eret` (in_WB_VALID & in_ERET, in any state other than ENTER):
  - Pulse out_BK with out_NIE = 1 in the next cycle.
  - Clear the highest set ISR bit. If ISR = 0, only the IE restore occurs.
- Address arithmetic is 32-bit modulo; +4 and the vector add wrap silently.

## Timing
- Reset values:
  - State IDLE; pend, ISR and the edge register all 0.
  - out_BK, out_NIE, out_EPC_WE, out_FLUSH = 0.
  - out_EPC, out_VEC_PC = 0; out_CODE = 0; out_ISR = 0.
- All outputs are registered.
- Latency: edge sampled at cycle N → pend at N+1 → WAIT_WB at N+2. If WB_VALID occurs at cycle M ≥ N+2, ENTER strobes are high during M+1.
- The `eret` pulse appears 1 cycle after the retiring cycle.
- out_BK from ENTER and out_BK from `eret` cannot coincide: `eret` is ignored while in ENTER. The pipeline guarantees no retirement in the ENTER cycle because of the flush.
- Reset mid-WAIT_WB or mid-ENTER aborts immediately; no partial strobes follow.

## Configuration
- INT_NEST_EN defined: prio_ok[i] = 1 iff i is greater than the index of the highest set ISR bit (prio_ok = all ones when ISR = 0). Up to 4 nested levels.
- INT_NEST_EN undefined: prio_ok = {4{ISR == 0}}, so at most one handler is in service. `eret` clears all of ISR.

## Test plan
- Reset, then IE=1, INM=0, pulse IRQ[1], WB_VALID with PC=0x100 two cycles later → one ENTER cycle: EPC=0x104, CODE=1, VEC_PC=0x810, BK=1/NIE=0, ISR=0010.
- IRQ[0] and IRQ[2] rise in the same cycle → source 2 taken first, VEC_PC=0x820. After `eret` retires, source 0 is taken with VEC_PC=0x800.
- INM=0100, IRQ[2] edge → no entry and pend[2] held. Clear INM → entry occurs, CODE=2.
- IRQ edge while WB_VALID=0 for 5 cycles → stays in WAIT_WB, no strobes. Drop IE in cycle 3 → returns to IDLE with no ENTER.
- With INT_NEST_EN: ISR=0001, IRQ[3] → nested entry, ISR=1001; `eret` → ISR=0001, BK=1/NIE=1. Without INT_NEST_EN, the same stimulus gives no entry until `eret`.
- Assert in_RST during WAIT_WB → all outputs 0 next edge, pend and ISR cleared, no ENTER afterward.
